// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - pipelined WISHBONE instruction prefetcher with FWFT buffer to DECODE
// Optional: define FETCH_PREFETCH_BYPASS_EN for a zero-latency ack-to-DECODE path when the buffer is empty.
module fetch_prefetch #(
    parameter int G_ADDR_SIZE = 16,
    parameter int G_DATA_SIZE = 16,
    parameter int G_DEPTH     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    input  logic                   wb_stall_i,
    output logic [G_ADDR_SIZE-1:0] wb_addr_o,
    input  logic                   wb_ack_i,
    input  logic [G_DATA_SIZE-1:0] wb_data_i,
    output logic                   dc_valid_o,
    input  logic                   dc_ready_i,
    output logic [G_ADDR_SIZE-1:0] dc_addr_o,
    output logic [G_DATA_SIZE-1:0] dc_data_o,
    input  logic                   dc_valid_i,
    input  logic [G_ADDR_SIZE-1:0] dc_addr_i
);
    localparam int PW = $clog2(G_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] L_DEPTH = (CW + 1)'(G_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                 state;
    logic [G_ADDR_SIZE-1:0] req_pc;
    logic [G_ADDR_SIZE-1:0] rsp_pc;
    logic [CW-1:0]          in_flight;
    logic [CW-1:0]          fifo_cnt;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [G_ADDR_SIZE-1:0] fifo_addr [G_DEPTH];
    logic [G_DATA_SIZE-1:0] fifo_data [G_DEPTH];

    logic          flush;
    logic          accept;
    logic          ack_ok;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          bypass;
    logic          byp_take;
    logic          issue;
    logic          stb_nxt;
    logic [CW-1:0] in_flight_nxt;
    logic [CW-1:0] fifo_nxt;
    logic [CW:0]   reserved_nxt;

    always_comb begin
        flush      = dc_valid_i;
        accept     = wb_stb_o && !wb_stall_i;
        // Acks outside a live cycle, with nothing outstanding, or during a flush are dropped.
        ack_ok     = wb_cyc_o && wb_ack_i && (in_flight != '0) && !flush;
        fifo_empty = (fifo_cnt == '0);
        pop        = !fifo_empty && dc_ready_i;
`ifdef FETCH_PREFETCH_BYPASS_EN
        bypass     = fifo_empty && ack_ok;
        byp_take   = bypass && dc_ready_i;
`else
        bypass     = 1'b0;
        byp_take   = 1'b0;
`endif
        push          = ack_ok && !byp_take;
        in_flight_nxt = in_flight + CW'(accept) - CW'(ack_ok);
        fifo_nxt      = fifo_cnt + CW'(push) - CW'(pop);
        reserved_nxt  = {1'b0, in_flight_nxt} + {1'b0, fifo_nxt};
        // One slot is taken by the new strobe itself, so issue only below the limit.
        issue   = (state == S_RUN) && !flush && (!wb_stb_o || !wb_stall_i)
                  && (reserved_nxt < L_DEPTH);
        stb_nxt = issue || (wb_stb_o && wb_stall_i);
    end

    always_comb begin
        dc_valid_o = !fifo_empty || bypass;
        dc_addr_o  = '0;
        dc_data_o  = '0;
        if (!fifo_empty) begin
            dc_addr_o = fifo_addr[rd_ptr];
            dc_data_o = fifo_data[rd_ptr];
        end else if (bypass) begin
            dc_addr_o = rsp_pc;
            dc_data_o = wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            req_pc    <= '0;
            rsp_pc    <= '0;
            in_flight <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_addr_o <= '0;
        end else if (flush) begin
            // Dropping cyc for one cycle aborts whatever the slave still owes us.
            state     <= S_RUN;
            req_pc    <= dc_addr_i;
            rsp_pc    <= dc_addr_i;
            in_flight <= '0;
            fifo_cnt  <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
        end else begin
            in_flight <= in_flight_nxt;
            fifo_cnt  <= fifo_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (ack_ok) begin
                rsp_pc <= rsp_pc + G_ADDR_SIZE'(1);
            end
            if (issue) begin
                wb_addr_o <= req_pc;
                req_pc    <= req_pc + G_ADDR_SIZE'(1);
            end
            wb_stb_o <= stb_nxt;
            wb_cyc_o <= stb_nxt || (in_flight_nxt != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= rsp_pc;
            fifo_data[wr_ptr] <= wb_data_i;
        end
    end

endmodule
